// File: rtl/map_ss_seq.sv
// Save-state sequencer for discrete-latch mappers: streams mapper registers plus the
// index byte out to a byte sink on save, and writes them back from a byte source on load.
module map_ss_seq #(
   parameter int unsigned REG_CNT  = 1,
   parameter int unsigned IDX_ADDR = 127,
   parameter int unsigned WE_HOLD  = 4
) (
   input  logic       clk,
   input  logic       map_rst_n,
   input  logic       cmd_save,
   input  logic       cmd_load,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       ss_act,
   output logic [7:0] ss_addr,
   output logic       ss_we,
   output logic [7:0] ss_wdat,
   input  logic [7:0] ss_rdat,
   output logic [7:0] snk_dat,
   output logic       snk_vld,
   input  logic       snk_rdy,
   input  logic [7:0] src_dat,
   input  logic       src_vld,
   output logic       src_rdy
);

   localparam int unsigned AW = 8;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = $clog2(WE_HOLD + 1);

   localparam logic [AW-1:0] LAST_REG = AW'(REG_CNT - 1);
   localparam logic [AW-1:0] IDX      = AW'(IDX_ADDR);
   localparam logic [CW-1:0] WE_LAST  = CW'(WE_HOLD - 1);
   localparam logic [CW-1:0] WE_DONE  = CW'(WE_HOLD);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_OUT  = 3'd2;
   localparam logic [2:0] L_REQ  = 3'd3;
   localparam logic [2:0] L_WR   = 3'd4;
   localparam logic [2:0] L_CHK  = 3'd5;
   localparam logic [2:0] FIN    = 3'd6;

   logic [2:0]    state, state_nx;
   logic [CW-1:0] we_cnt, we_cnt_nx;
   logic          busy_nx, done_nx, err_nx, ss_act_nx, ss_we_nx;
   logic          snk_vld_nx, src_rdy_nx;
   logic [AW-1:0] ss_addr_nx, addr_adv;
   logic [DW-1:0] ss_wdat_nx, snk_dat_nx;

   // Register walk order: 0 .. REG_CNT-1, then the index byte.
   assign addr_adv = (ss_addr == LAST_REG) ? IDX : ss_addr + AW'(1);

   // State and all outputs registered; reset drops everything immediately.
   always_ff @(posedge clk or negedge map_rst_n) begin
      if (!map_rst_n) begin
         state   <= IDLE;
         we_cnt  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         ss_act  <= 1'b0;
         ss_addr <= '0;
         ss_we   <= 1'b0;
         ss_wdat <= '0;
         snk_dat <= '0;
         snk_vld <= 1'b0;
         src_rdy <= 1'b0;
      end else begin
         state   <= state_nx;
         we_cnt  <= we_cnt_nx;
         busy    <= busy_nx;
         done    <= done_nx;
         err     <= err_nx;
         ss_act  <= ss_act_nx;
         ss_addr <= ss_addr_nx;
         ss_we   <= ss_we_nx;
         ss_wdat <= ss_wdat_nx;
         snk_dat <= snk_dat_nx;
         snk_vld <= snk_vld_nx;
         src_rdy <= src_rdy_nx;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx   = state;
      we_cnt_nx  = we_cnt;
      busy_nx    = busy;
      done_nx    = 1'b0;
      err_nx     = err;
      ss_act_nx  = ss_act;
      ss_addr_nx = ss_addr;
      ss_we_nx   = ss_we;
      ss_wdat_nx = ss_wdat;
      snk_dat_nx = snk_dat;
      snk_vld_nx = snk_vld;
      src_rdy_nx = src_rdy;

      case (state)
         IDLE: begin
            if (cmd_save || cmd_load) begin
               err_nx     = 1'b0;
               busy_nx    = 1'b1;
               ss_act_nx  = 1'b1;
               ss_addr_nx = '0;
               // Save has priority when both commands collide.
               state_nx   = cmd_save ? S_ADDR : L_REQ;
               src_rdy_nx = !cmd_save;
            end
         end

         S_ADDR: begin
            snk_dat_nx = ss_rdat;
            snk_vld_nx = 1'b1;
            state_nx   = S_OUT;
         end

         S_OUT: begin
            if (snk_vld && snk_rdy) begin
               snk_vld_nx = 1'b0;
               if (ss_addr == IDX) begin
                  done_nx  = 1'b1;
                  state_nx = FIN;
               end else begin
                  ss_addr_nx = addr_adv;
                  state_nx   = S_ADDR;
               end
            end
         end

         L_REQ: begin
            if (src_vld && src_rdy) begin
               ss_wdat_nx = src_dat;
               src_rdy_nx = 1'b0;
               // The index byte is only compared, never written back.
               if (ss_addr == IDX) begin
                  state_nx = L_CHK;
               end else begin
                  ss_we_nx  = 1'b1;
                  we_cnt_nx = '0;
                  state_nx  = L_WR;
               end
            end
         end

         L_WR: begin
            // WE_HOLD cycles of strobe, then one quiet cycle with address/data held.
            if (we_cnt == WE_DONE) begin
               ss_addr_nx = addr_adv;
               src_rdy_nx = 1'b1;
               state_nx   = L_REQ;
            end else begin
               if (we_cnt == WE_LAST) begin
                  ss_we_nx = 1'b0;
               end
               we_cnt_nx = we_cnt + CW'(1);
            end
         end

         L_CHK: begin
            if (ss_wdat != ss_rdat) begin
               err_nx = 1'b1;
            end
            done_nx  = 1'b1;
            state_nx = FIN;
         end

         FIN: begin
            busy_nx    = 1'b0;
            ss_act_nx  = 1'b0;
            ss_addr_nx = '0;
            state_nx   = IDLE;
         end

         default: begin
            busy_nx    = 1'b0;
            ss_act_nx  = 1'b0;
            ss_addr_nx = '0;
            ss_we_nx   = 1'b0;
            snk_vld_nx = 1'b0;
            src_rdy_nx = 1'b0;
            state_nx   = IDLE;
         end
      endcase
   end

   a_no_overlap: assert property (@(posedge clk) disable iff (!map_rst_n)
      !(snk_vld && src_rdy));

   a_we_in_wr: assert property (@(posedge clk) disable iff (!map_rst_n)
      ss_we |-> (state == L_WR));

endmodule
